// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Multi-cycle instruction fetch controller. Owns the PC, issues
//               one imem request at a time, hands the fetched word to decode
//               over a valid/ready handshake, then advances sequentially or
//               by a signed branch offset. Supports level halt and a sticky
//               memory-timeout fault.
//               Optional build macro PERF_CNT_EN adds saturating retired and
//               stall counters (o_retired_cnt, o_stall_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int          PC_W     = 8,
    parameter int          INSTR_W  = 16,
    parameter int          MAX_WAIT = 15,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               o_imem_req,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_data,
    output logic               o_instr_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_instr_pc,
    input  logic               i_core_ready,
    input  logic               i_branch_taken,
    input  logic [PC_W-1:0]    i_branch_off,
    input  logic               i_halt,
    output logic               o_halted,
    output logic               o_fault
`ifdef PERF_CNT_EN
    ,
    output logic [15:0]        o_retired_cnt,
    output logic [15:0]        o_stall_cnt
`endif
);

    localparam int                c_CNT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_WAIT = c_CNT_W'(MAX_WAIT - 1);
    localparam logic [PC_W-1:0]    c_RESET_PC  = PC_W'(RESET_PC);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_VALID  = 3'd2,
        S_HALTED = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PC_W-1:0]      r_pc;
    logic [c_CNT_W-1:0]   r_wait_cnt;
    logic [INSTR_W-1:0]   r_instr;
    logic [PC_W-1:0]      r_instr_pc;
    logic                 w_handshake;
    logic [PC_W-1:0]      w_pc_step;
    logic [PC_W-1:0]      w_pc_next;

    // Next-state decode and Moore outputs; handshake only exists in VALID.
    always_comb begin
        w_state_nxt   = r_state;
        w_handshake   = 1'b0;
        o_imem_req    = 1'b0;
        o_instr_valid = 1'b0;
        o_halted      = 1'b0;
        o_fault       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                o_imem_req = 1'b1;
                // An ack on the last allowed cycle wins over the timeout.
                if (i_imem_ack) begin
                    w_state_nxt = S_VALID;
                end else if (r_wait_cnt == c_LAST_WAIT) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_VALID: begin
                o_instr_valid = 1'b1;
                w_handshake   = i_core_ready;
                if (i_core_ready) begin
                    w_state_nxt = i_halt ? S_HALTED : S_FETCH;
                end
            end
            S_HALTED: begin
                o_halted = 1'b1;
                if (!i_halt) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FAULT: begin
                o_fault = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next PC is relative to the delivered instruction; same-width add wraps
    // modulo 2^PC_W, which also makes the offset behave as sign-extended.
    assign w_pc_step = i_branch_taken ? i_branch_off : PC_W'(1);
    assign w_pc_next = r_instr_pc + w_pc_step;

    assign o_imem_addr = r_pc;
    assign o_instr     = r_instr;
    assign o_instr_pc  = r_instr_pc;

    // State register, PC, timeout counter and captured instruction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_pc       <= c_RESET_PC;
            r_wait_cnt <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_FETCH) begin
                if (i_imem_ack) begin
                    r_instr    <= i_imem_data;
                    r_instr_pc <= r_pc;
                    r_wait_cnt <= '0;
                end else begin
                    r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                end
            end
            if (w_handshake) begin
                r_pc <= w_pc_next;
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [15:0] r_retired_cnt;
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = ((r_state == S_FETCH) && !i_imem_ack) ||
                     ((r_state == S_VALID) && !i_core_ready);

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_retired_cnt <= '0;
            r_stall_cnt   <= '0;
        end else begin
            if (w_handshake && (r_retired_cnt != 16'hFFFF)) begin
                r_retired_cnt <= r_retired_cnt + 16'd1;
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign o_retired_cnt = r_retired_cnt;
    assign o_stall_cnt   = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Scoreboard bench for fetch_sequencer. A driver answers fetches
//               from a random memory image and drives decode-side stimulus
//               while a transaction-level model predicts PC flow; a monitor
//               compares every delivered instruction against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int PC_W     = 8;
    localparam int INSTR_W  = 16;
    localparam int MAX_WAIT = 15;
    localparam int RESET_PC = 0;

    logic               clk = 1'b0;
    logic               rst;
    logic               o_imem_req;
    logic [PC_W-1:0]    o_imem_addr;
    logic               i_imem_ack;
    logic [INSTR_W-1:0] i_imem_data;
    logic               o_instr_valid;
    logic [INSTR_W-1:0] o_instr;
    logic [PC_W-1:0]    o_instr_pc;
    logic               i_core_ready;
    logic               i_branch_taken;
    logic [PC_W-1:0]    i_branch_off;
    logic               i_halt;
    logic               o_halted;
    logic               o_fault;
`ifdef PERF_CNT_EN
    logic [15:0]        o_retired_cnt;
    logic [15:0]        o_stall_cnt;
`endif

    fetch_sequencer #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .MAX_WAIT (MAX_WAIT),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_ack     (i_imem_ack),
        .i_imem_data    (i_imem_data),
        .o_instr_valid  (o_instr_valid),
        .o_instr        (o_instr),
        .o_instr_pc     (o_instr_pc),
        .i_core_ready   (i_core_ready),
        .i_branch_taken (i_branch_taken),
        .i_branch_off   (i_branch_off),
        .i_halt         (i_halt),
        .o_halted       (o_halted),
        .o_fault        (o_fault)
`ifdef PERF_CNT_EN
        ,
        .o_retired_cnt  (o_retired_cnt),
        .o_stall_cnt    (o_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } exp_t;

    typedef struct packed {
        bit              taken;
        logic [PC_W-1:0] off;
        bit              halt;
    } force_t;

    exp_t   sb[$];
    force_t fq[$];

    logic [INSTR_W-1:0] mem [256];

    int n_checks = 0;
    int n_err    = 0;
    int n_hs     = 0;

    // Transaction-level model state
    int model_pc;
    int cur_pc;
    int fetch_wait;
    int cur_delay;
    bit exp_req;
    bit exp_valid;
    bit exp_halted;
    int halt_hold;

    // Stimulus knobs
    int fix_delay = -1;
    int max_delay = 14;
    int ready_pct = 100;
    int halt_pct  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick_delay();
        if (fix_delay >= 0) return fix_delay;
        return int'($urandom_range(0, max_delay));
    endfunction

    task automatic do_reset(input int n, input bit ack_in_reset);
        @(negedge clk);
        rst            = 1'b0;
        i_core_ready   = 1'b0;
        i_halt         = 1'b0;
        i_branch_taken = 1'b0;
        for (int k = 0; k < n; k++) begin
            i_imem_ack  = ack_in_reset;
            i_imem_data = INSTR_W'($urandom);
            @(negedge clk);
        end
        chk("rst_req",      32'(o_imem_req),    32'(0));
        chk("rst_valid",    32'(o_instr_valid), 32'(0));
        chk("rst_halted",   32'(o_halted),      32'(0));
        chk("rst_fault",    32'(o_fault),       32'(0));
        chk("rst_addr",     32'(o_imem_addr),   32'(RESET_PC));
        chk("rst_instr",    32'(o_instr),       32'(0));
        chk("rst_instr_pc", 32'(o_instr_pc),    32'(0));
        // Release; an ack seen during the IDLE cycle must be ignored.
        rst         = 1'b1;
        i_imem_ack  = ack_in_reset;
        model_pc    = RESET_PC;
        cur_pc      = 0;
        fetch_wait  = 0;
        cur_delay   = pick_delay();
        exp_req     = 1'b1;
        exp_valid   = 1'b0;
        exp_halted  = 1'b0;
        halt_hold   = 0;
        sb.delete();
    endtask

    task automatic cycle();
        exp_t   e;
        force_t f;
        int     off;
        bit     nx_req, nx_valid, nx_halted;
        @(negedge clk);
        chk("imem_req",    32'(o_imem_req),    32'(exp_req));
        chk("instr_valid", 32'(o_instr_valid), 32'(exp_valid));
        chk("halted",      32'(o_halted),      32'(exp_halted));
        chk("fault",       32'(o_fault),       32'(0));
        nx_req    = exp_req;
        nx_valid  = exp_valid;
        nx_halted = exp_halted;
        i_imem_data = INSTR_W'($urandom);
        i_imem_ack  = 1'b0;
        if (exp_req) begin
            chk("imem_addr", 32'(o_imem_addr), 32'(model_pc));
            if (fetch_wait >= cur_delay) begin
                i_imem_ack  = 1'b1;
                i_imem_data = mem[model_pc];
                e.instr     = mem[model_pc];
                e.pc        = PC_W'(model_pc);
                sb.push_back(e);
                cur_pc      = model_pc;
                fetch_wait  = 0;
                cur_delay   = pick_delay();
                nx_req      = 1'b0;
                nx_valid    = 1'b1;
            end else begin
                fetch_wait++;
            end
        end else begin
            i_imem_ack = ($urandom_range(0, 3) == 0);
        end
        i_core_ready   = (int'($urandom_range(0, 99)) < ready_pct);
        i_branch_taken = $urandom_range(0, 1) == 1;
        i_branch_off   = PC_W'($urandom);
        if (exp_halted) begin
            i_halt = (halt_hold > 0);
            if (halt_hold > 0) halt_hold--;
            if (!i_halt) begin
                nx_halted = 1'b0;
                nx_req    = 1'b1;
            end
        end else begin
            i_halt = (int'($urandom_range(0, 99)) < halt_pct);
        end
        if (exp_valid && i_core_ready) begin
            if (fq.size() != 0) begin
                f              = fq.pop_front();
                i_branch_taken = f.taken;
                i_branch_off   = f.off;
                i_halt         = f.halt;
            end
            if (i_branch_taken)
                off = (int'(i_branch_off) >= 128) ? int'(i_branch_off) - 256 : int'(i_branch_off);
            else
                off = 1;
            model_pc = (cur_pc + off + 256) % 256;
            n_hs++;
            nx_valid = 1'b0;
            if (i_halt) begin
                nx_halted = 1'b1;
                halt_hold = int'($urandom_range(0, 3));
            end else begin
                nx_req = 1'b1;
            end
        end
        exp_req    = nx_req;
        exp_valid  = nx_valid;
        exp_halted = nx_halted;
    endtask

    task automatic push_force(input bit taken, input logic [PC_W-1:0] off, input bit halt);
        force_t f;
        f.taken = taken;
        f.off   = off;
        f.halt  = halt;
        fq.push_back(f);
    endtask

    // Monitor: pops the scoreboard on every decode handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && o_instr_valid && i_core_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL sb_underflow: got handshake pc=%0h expected none", o_instr_pc);
                end else begin
                    e = sb.pop_front();
                    chk("instr",    32'(o_instr),    32'(e.instr));
                    chk("instr_pc", 32'(o_instr_pc), 32'(e.pc));
                end
            end
        end
    end

    // Driver / directed phases
    initial begin
        rst            = 1'b0;
        i_imem_ack     = 1'b0;
        i_imem_data    = '0;
        i_core_ready   = 1'b0;
        i_branch_taken = 1'b0;
        i_branch_off   = '0;
        i_halt         = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = INSTR_W'($urandom);

        // Back-to-back sequential fetch: 0,1,2,3,4 then pc 5 with 3-cycle ack delay
        fix_delay = 0;
        do_reset(3, 1'b0);
        for (int k = 0; k < 5; k++) push_force(1'b0, '0, 1'b0);
        for (int k = 0; k < 8; k++) cycle();
        fix_delay = 3;
        for (int k = 0; k < 4; k++) cycle();
        // Wrap-around branches, then branch+halt together at instr_pc 10
        fix_delay = -1;
        push_force(1'b1, 8'hFE, 1'b0);   // 5  -> 3
        push_force(1'b1, 8'hFA, 1'b0);   // 3  -> FD
        push_force(1'b1, 8'h02, 1'b0);   // FD -> FF
        push_force(1'b0, 8'h00, 1'b0);   // FF -> 00
        push_force(1'b1, 8'h0A, 1'b0);   // 00 -> 0A
        push_force(1'b1, 8'h04, 1'b1);   // 0A -> 0E, halt
        for (int k = 0; k < 150 && fq.size() != 0; k++) cycle();
        for (int k = 0; k < 10; k++) cycle();

        // Randomised traffic
        ready_pct = 70;
        halt_pct  = 10;
        for (int k = 0; k < 600; k++) cycle();

        // Ack on the last allowed FETCH cycle is still accepted
        fix_delay = MAX_WAIT - 1;
        for (int k = 0; k < 80; k++) cycle();

        // Reset in the middle of a fetch wait, with stray acks during reset/IDLE
        fix_delay = 10;
        for (int k = 0; k < 40 && !(exp_req && fetch_wait == 4); k++) cycle();
        fix_delay = 3;
        do_reset(2, 1'b1);
        fix_delay = -1;
        for (int k = 0; k < 200; k++) cycle();

        // Timeout: no ack for MAX_WAIT cycles
        do_reset(2, 1'b0);
        i_imem_ack = 1'b0;
        for (int c = 1; c <= MAX_WAIT + 5; c++) begin
            @(negedge clk);
            if (c <= MAX_WAIT) begin
                chk("to_req",   32'(o_imem_req), 32'(1));
                chk("to_fault", 32'(o_fault),    32'(0));
                chk("to_addr",  32'(o_imem_addr), 32'(RESET_PC));
                i_imem_ack = 1'b0;
            end else begin
                chk("to_fault",  32'(o_fault),       32'(1));
                chk("to_req",    32'(o_imem_req),    32'(0));
                chk("to_valid",  32'(o_instr_valid), 32'(0));
                i_imem_ack = $urandom_range(0, 1) == 1;
            end
        end
        do_reset(2, 1'b1);
        for (int k = 0; k < 100; k++) cycle();

        chk("enough_handshakes", 32'(n_hs >= 100), 32'(1));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle fetch controller that owns the program counter and sequences instruction fetch for the core. It issues one request at a time to instruction memory and waits for a completion handshake. It presents the fetched instruction to decode with a valid/ready handshake, then advances the PC sequentially or by a signed branch offset. It also handles halt and detects memory timeouts.

Parameters:
PC_W, 8, PC and instruction-address width
INSTR_W, 16, instruction word width
MAX_WAIT, 15, consecutive un-acked FETCH cycles allowed before fault (>=1)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-low reset
imem_req  out  1  fetch request; high exactly while in FETCH
imem_addr  out  PC_W  fetch address; equals pc
imem_ack  in  1  memory returns imem_data this cycle
imem_data  in  INSTR_W  instruction word
instr_valid  out  1  instr/instr_pc valid to decode
instr  out  INSTR_W  captured instruction
instr_pc  out  PC_W  address the instruction was fetched from
core_ready  in  1  decode accepts instruction
branch_taken  in  1  redirect for the accepted instruction
branch_off  in  PC_W  signed offset, relative to instr_pc
halt  in  1  level halt request
halted  out  1  in HALTED
fault  out  1  sticky memory-timeout flag

Behaviour:
- Reset is synchronous: when rst==0 at posedge, the block loads state=IDLE, pc=RESET_PC, wait_cnt=0, instr=0, instr_pc=0, and clears fault. All outputs are therefore 0, except imem_addr, which equals RESET_PC.
- Reset mid-operation drops any outstanding request. A late imem_ack is ignored because state is IDLE.
- States: IDLE, FETCH, VALID, HALTED, FAULT.
- IDLE to FETCH unconditionally. The first imem_req is seen in the 2nd cycle after rst rises.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_data, instr_pc<=pc, wait_cnt<=0, go to VALID.
  - Each cycle without ack increments wait_cnt.
  - If MAX_WAIT consecutive FETCH cycles pass with no ack, go to FAULT. An ack on FETCH cycle MAX_WAIT is still accepted.
- VALID:
  - instr_valid=1; instr and instr_pc are held stable until the handshake.
  - Handshake = instr_valid & core_ready. On the handshake cycle, branch_taken, branch_off and halt are sampled.
  - pc <= instr_pc + sign_ext(branch_off) if branch_taken, else pc <= instr_pc + 1.
  - Arithmetic is modulo 2^PC_W; wrap-around is silent.
  - Next state is HALTED if halt==1, else FETCH.
  - Without a handshake, the block stays in VALID and branch/halt are ignored.
- HALTED:
  - halted=1, imem_req=0, pc held.
  - When halt==0, go to FETCH the next cycle and resume at the held pc.
- FAULT:
  - fault=1, imem_req=0, instr_valid=0.
  - Exits only via reset.
- Halt asserted during FETCH does not abort it: the fetch completes and the instruction is delivered. Halt takes effect at that instruction's handshake.
- Branch and halt on the same handshake: pc is set to the branch target, then the block enters HALTED.
- imem_ack outside FETCH is ignored.
- Throughput: at best 1 instruction per 2 cycles (FETCH with immediate ack, then VALID with core_ready high).

Optional Feature:
PERF_CNT_EN
- Defined: adds outputs retired_cnt[15:0] and stall_cnt[15:0].
  - retired_cnt increments on each VALID handshake.
  - stall_cnt increments on each FETCH cycle without ack and each VALID cycle without core_ready.
  - Both saturate at 16'hFFFF and are cleared by reset.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then imem_ack tied 1 and core_ready tied 1. Required: imem_addr sequence 0,1,2,3 on successive FETCH cycles; instr_valid on alternating cycles; instr_pc matches each address.
- Fetch at pc=5, imem_ack delayed 3 cycles. Required: imem_req high 4 cycles with addr 5; instr captured on the ack cycle; instr_valid the next cycle.
- instr_pc=3, branch_taken=1, branch_off=8'hFA (-6). Required: next imem_addr=8'hFD (wrap). Also instr_pc=8'hFF with no branch gives next imem_addr=8'h00.
- Timeout with MAX_WAIT=15 and imem_ack=0. Required: fault=1 from cycle 16 of FETCH, imem_req=0 thereafter, stays set until rst=0. A separate run with ack on FETCH cycle 15 must be accepted, with no fault.
- halt=1 together with branch_taken=1, off=+4, at handshake for instr_pc=10. Required: halted=1, pc=14, no imem_req. After halt=0, imem_req appears the next cycle with addr 14.
- rst=0 during a FETCH wait, with ack arriving while in reset or IDLE. Required: ack ignored; imem_addr restarts at RESET_PC; instr_valid stays 0 until the new fetch acks.
